scene_sequencer: RTL and testbench
==================================

Name: scene_sequencer

Overview:
Frame-synchronous controller that selects the active background layer (grass, UW bouncing, solid blue, solid green) and sequences cross-fade transitions between them. It also steps the goose sprite's animation frame. It sits between the hvsync generator (frame tick), the user inputs (ui_in) and the top-level pixel mux / colour-scaling stage. All decisions are taken on frame boundaries, so a scene never changes mid-frame.

Parameters:
HOLD_FRAMES, 240, frames a scene dwells in auto mode before advancing (>=2)
FADE_STEP, 2, frames per fade-level step (>=1)
ANIM_DIV, 8, frames per goose animation frame (>=1)
DEBOUNCE_FRAMES, 3, consecutive high frame samples needed to accept a button press (>=1)

Ports:
clk  in  1  pixel clock
rst_n  in  1  reset
frame_tick  in  1  one-cycle pulse per frame at start of vblank
auto_en  in  1  1 = auto/button advance; 0 = manual_sel drives scene
manual_sel  in  2  requested background ID in manual mode
btn_next  in  1  raw asynchronous push button, active high
bg_sel  out  2  active background ID, to the pixel mux
fade  out  2  brightness level: 3 = full, 0 = black
goose_frame  out  2  goose animation frame index
scene_changed  out  1  one-cycle pulse when bg_sel updates
busy  out  1  high in any state other than SHOW

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: bg_sel=0, fade=3, goose_frame=0, scene_changed=0, busy=0, state=SHOW, all counters 0, target=0.
- All state changes happen only in a cycle where frame_tick=1. Outputs are registered and update the cycle after that frame_tick.
- btn_next: synchronised with a 2-FF synchroniser, then sampled only on frame_tick.
  - Press event: generated when the sample has been high for DEBOUNCE_FRAMES consecutive ticks.
  - Re-arm: requires one low sample before another press event can be generated.
- Step counter step_cnt: counts frame ticks. A "step" completes at a tick where step_cnt==FADE_STEP-1; step_cnt then wraps to 0.
- FSM states:
  - SHOW: fade=3, busy=0. dwell counts ticks. Triggers are evaluated at each tick, highest priority first:
    (1) auto_en=0 and manual_sel!=bg_sel -> target=manual_sel
    (2) auto_en=1 and press event -> target=bg_sel+1 (mod 4)
    (3) auto_en=1 and dwell==HOLD_FRAMES-1 -> target=bg_sel+1 (mod 4)
    On any trigger: fade<=2, step_cnt<=0, state->FADE_OUT.
  - FADE_OUT: on step complete, fade decrements. When fade reaches 0, state->SWAP.
  - SWAP: fade=0. On the next tick: bg_sel<=target, scene_changed pulses for one cycle, fade<=1, step_cnt<=0, state->FADE_IN.
  - FADE_IN: on step complete, fade increments. When fade reaches 3: state->SHOW, dwell<=0.
- Triggers arriving during FADE_OUT, SWAP or FADE_IN are dropped.
  - Press events in these states are discarded.
  - A manual_sel mismatch is simply re-evaluated once back in SHOW.
- A manual_sel change mid-fade does not alter target.
- dwell is held at 0 while auto_en=0. Toggling auto_en does not abort a fade in progress.
- goose_frame increments every ANIM_DIV ticks and wraps 3->0. It runs independently of the FSM and in all states.
- Counter widths: $clog2 of the respective parameter (minimum 1 bit). Every counter wraps explicitly; none overflows.
- Reset asserted mid-fade returns immediately to the reset values.

Optional Feature:
SCENE_SEQ_RANDOM_EN:
- Defined: an 8-bit Fibonacci LFSR (taps x^8+x^6+x^5+x^4+1, reset seed 8'hA5) advances on every frame_tick. Auto/button triggers (2) and (3) use target=lfsr[1:0]; if that equals bg_sel, target=lfsr[1:0]+1 (mod 4). A trigger therefore always changes the scene.
- Undefined: sequential target as described above; no LFSR logic is present.

Decomposition:
- Package scene_pkg holds:
  - state enum {SHOW, FADE_OUT, SWAP, FADE_IN}
  - FADE_FULL=2'd3 and FADE_BLACK=2'd0
  - background IDs BG_GRASS=0, BG_UW=1, BG_BLUE=2, BG_GREEN=3
  - LFSR seed constant
- One sub-module, frame_debounce: 2-FF synchroniser plus frame-sampled debounce counter, parameterised by DEBOUNCE_FRAMES, emitting a one-cycle press event.

Test Plan:
- Reset, then 10 ticks with auto_en=1 and HOLD_FRAMES=240: bg_sel=0, fade=3, busy=0 throughout; goose_frame=1 after tick 8 (ANIM_DIV=8).
- auto_en=1, HOLD_FRAMES=4, FADE_STEP=1:
  - tick 3: fade=2
  - tick 4: fade=1
  - tick 5: fade=0, state SWAP
  - tick 6: bg_sel=1, scene_changed pulses, fade=1
  - tick 7: fade=2
  - tick 8: fade=3, busy=0
- auto_en=0, manual_sel=3 set in SHOW: fade sequence 2,1,0, then bg_sel=3. Changing manual_sel to 2 mid-fade still yields bg_sel=3, followed by a second transition to 2.
- btn_next high for 2 ticks with DEBOUNCE_FRAMES=3: no transition. Held high for 3 ticks: exactly one transition to bg_sel+1. Holding longer produces no further press event until a low sample is seen.
- Reset asserted during FADE_IN with fade=1: next cycle bg_sel=0, fade=3, busy=0, goose_frame=0.
- With SCENE_SEQ_RANDOM_EN defined, run 50 auto transitions: bg_sel differs from its previous value on every scene_changed pulse, and the first target matches the LFSR value computed from seed 8'hA5.

Source files
------------

// File: rtl/scene_pkg.sv
// Shared types and constants for the scene sequencer.
package scene_pkg;

  typedef enum logic [1:0] {SHOW, FADE_OUT, SWAP, FADE_IN} state_t;

  localparam logic [1:0] FADE_FULL  = 2'd3;
  localparam logic [1:0] FADE_BLACK = 2'd0;

  localparam logic [1:0] BG_GRASS = 2'd0;
  localparam logic [1:0] BG_UW    = 2'd1;
  localparam logic [1:0] BG_BLUE  = 2'd2;
  localparam logic [1:0] BG_GREEN = 2'd3;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_debounce.sv
// Button conditioning: 2-FF synchroniser, then a debounce counter that only
// advances on frame ticks. press is a one-cycle pulse in the accepting tick;
// the button must be seen low once before the next press can fire.
module frame_debounce
  import scene_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  input  logic btn,
  output logic press
);

  localparam int CW = cnt_w(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_FRAMES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          armed;
  logic          sample;

  assign sample = sync[1];

  // bring the asynchronous button into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b00;
    else        sync <= {sync[0], btn};
  end

  // count consecutive high frame samples; disarm after a press until a low sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      armed <= 1'b1;
    end else if (frame_tick) begin
      if (!sample) begin
        cnt   <= '0;
        armed <= 1'b1;
      end else if (armed) begin
        if (cnt == CNT_LAST) begin
          cnt   <= '0;
          armed <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign press = frame_tick & sample & armed & (cnt == CNT_LAST);

endmodule

// File: rtl/scene_sequencer.sv
// Frame-synchronous background selector with cross-fade sequencing and goose
// animation stepping. Every state change happens in a frame_tick cycle.
// Build option SCENE_SEQ_RANDOM_EN: auto/button advances pick a pseudo-random
// different background from an 8-bit LFSR instead of bg_sel+1.
module scene_sequencer
  import scene_pkg::*;
#(
  parameter int HOLD_FRAMES     = 240,
  parameter int FADE_STEP       = 2,
  parameter int ANIM_DIV        = 8,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       auto_en,
  input  logic [1:0] manual_sel,
  input  logic       btn_next,
  output logic [1:0] bg_sel,
  output logic [1:0] fade,
  output logic [1:0] goose_frame,
  output logic       scene_changed,
  output logic       busy
);

  localparam int DW = cnt_w(HOLD_FRAMES);
  localparam int SW = cnt_w(FADE_STEP);
  localparam int AW = cnt_w(ANIM_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(HOLD_FRAMES - 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(FADE_STEP - 1);
  localparam logic [AW-1:0] ANIM_LAST  = AW'(ANIM_DIV - 1);

  state_t        state, state_n;
  logic [1:0]    target, target_n;
  logic [1:0]    bg_n, fade_n;
  logic          chg_n, trig;
  logic [SW-1:0] step_cnt, step_n;
  logic [DW-1:0] dwell, dwell_n;
  logic [AW-1:0] anim_cnt;
  logic [1:0]    auto_tgt;
  logic          press;

  frame_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .btn        (btn_next),
    .press      (press)
  );

`ifdef SCENE_SEQ_RANDOM_EN
  logic [7:0] lfsr;

  // free-running per-frame LFSR for scene picks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          lfsr <= LFSR_SEED;
    else if (frame_tick) lfsr <= lfsr_next(lfsr);
  end

  // a draw equal to the current scene is bumped so a trigger always changes it
  assign auto_tgt = (lfsr[1:0] == bg_sel) ? lfsr[1:0] + 2'd1 : lfsr[1:0];
`else
  assign auto_tgt = bg_sel + 2'd1;
`endif

  // goose animation divider, independent of the scene FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anim_cnt    <= '0;
      goose_frame <= 2'd0;
    end else if (frame_tick) begin
      if (anim_cnt == ANIM_LAST) begin
        anim_cnt    <= '0;
        goose_frame <= goose_frame + 2'd1;
      end else begin
        anim_cnt <= anim_cnt + 1'b1;
      end
    end
  end

  // sequencer state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= SHOW;
      bg_sel        <= BG_GRASS;
      fade          <= FADE_FULL;
      target        <= BG_GRASS;
      step_cnt      <= '0;
      dwell         <= '0;
      scene_changed <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      bg_sel        <= bg_n;
      fade          <= fade_n;
      target        <= target_n;
      step_cnt      <= step_n;
      dwell         <= dwell_n;
      scene_changed <= chg_n;
      busy          <= (state_n != SHOW);
    end
  end

  // next-state: triggers in SHOW, then fade down, swap at black, fade up
  always_comb begin
    state_n  = state;
    bg_n     = bg_sel;
    fade_n   = fade;
    target_n = target;
    step_n   = step_cnt;
    dwell_n  = dwell;
    chg_n    = 1'b0;
    trig     = 1'b0;
    if (frame_tick) begin
      case (state)
        SHOW: begin
          if (!auto_en && (manual_sel != bg_sel)) begin
            trig     = 1'b1;
            target_n = manual_sel;
          end else if (auto_en && (press || dwell == DWELL_LAST)) begin
            trig     = 1'b1;
            target_n = auto_tgt;
          end
          if (trig) begin
            fade_n  = FADE_FULL - 2'd1;
            step_n  = '0;
            state_n = FADE_OUT;
          end else if (auto_en) begin
            dwell_n = (dwell == DWELL_LAST) ? '0 : dwell + 1'b1;
          end
        end
        FADE_OUT: begin
          if (step_cnt == STEP_LAST) begin
            step_n = '0;
            fade_n = fade - 2'd1;
            if (fade == FADE_BLACK + 2'd1) state_n = SWAP;
          end else begin
            step_n = step_cnt + 1'b1;
          end
        end
        SWAP: begin
          bg_n    = target;
          chg_n   = 1'b1;
          fade_n  = FADE_BLACK + 2'd1;
          step_n  = '0;
          state_n = FADE_IN;
        end
        FADE_IN: begin
          if (step_cnt == STEP_LAST) begin
            step_n = '0;
            fade_n = fade + 2'd1;
            if (fade == FADE_FULL - 2'd1) begin
              state_n = SHOW;
              dwell_n = '0;
            end
          end else begin
            step_n = step_cnt + 1'b1;
          end
        end
        default: state_n = SHOW;
      endcase
      if (!auto_en) dwell_n = '0;
    end
  end

endmodule

// File: tb/tb_scene_sequencer.sv
// Bench for scene_sequencer: two instances (short hold / fast fade, and the
// default timing) share one stimulus stream. A timeline model checks both
// every cycle; literal expectations pin the model at key points.
module tb_scene_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       auto_en = 1'b1;
  logic       btn_next = 1'b0;
  logic [1:0] manual_sel = 2'd0;

  logic [1:0] bg_a, fade_a, goose_a;
  logic       chg_a, busy_a;
  logic [1:0] bg_b, fade_b, goose_b;
  logic       chg_b, busy_b;

  int n_chk = 0;
  int n_err = 0;

`ifdef SCENE_SEQ_RANDOM_EN
  // LFSR A5 -> 4A -> 95 -> 2A; the trigger on the 4th tick draws 2A[1:0] = 2
  localparam int FIRST_BG = 2;
`else
  localparam int FIRST_BG = 1;
`endif

  always #5 clk = ~clk;

  scene_sequencer #(.HOLD_FRAMES(4), .FADE_STEP(1), .ANIM_DIV(8), .DEBOUNCE_FRAMES(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .auto_en(auto_en),
    .manual_sel(manual_sel), .btn_next(btn_next), .bg_sel(bg_a), .fade(fade_a),
    .goose_frame(goose_a), .scene_changed(chg_a), .busy(busy_a)
  );

  scene_sequencer dut_b (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .auto_en(auto_en),
    .manual_sel(manual_sel), .btn_next(btn_next), .bg_sel(bg_b), .fade(fade_b),
    .goose_frame(goose_b), .scene_changed(chg_b), .busy(busy_b)
  );

  // ---------------- model ----------------
  typedef struct {
    int         bg, fade, goose, ticks, dwell, k, tgt, run;
    bit         chg, busy;
    logic [7:0] lfsr;
  } mdl_t;

  function automatic mdl_t mdl_rst();
    mdl_t m;
    m.bg = 0; m.fade = 3; m.goose = 0; m.ticks = 0; m.dwell = 0;
    m.k = 0; m.tgt = 0; m.run = 0; m.chg = 0; m.busy = 0; m.lfsr = 8'hA5;
    return m;
  endfunction

  // brightness k ticks after the trigger tick (k=0 is the trigger itself)
  function automatic int fade_at(input int k, input int fs);
    if (k < fs)              return 2;
    else if (k < 2*fs)       return 1;
    else if (k == 2*fs)      return 0;
    else if (k < 3*fs + 1)   return 1;
    else if (k < 4*fs + 1)   return 2;
    else                     return 3;
  endfunction

  function automatic mdl_t mdl_tick(input mdl_t mi, input int hold, input int fs,
                                    input int anim, input int deb, input bit au,
                                    input int msel, input bit btn);
    mdl_t m;
    bit   press;
    int   nxt;
    m = mi;
    m.chg = 0;
    m.ticks++;
    m.goose = (m.ticks / anim) % 4;
    if (btn) begin
      if (m.run <= deb) m.run++;
    end else begin
      m.run = 0;
    end
    press = btn && (m.run == deb);
`ifdef SCENE_SEQ_RANDOM_EN
    nxt = (int'(m.lfsr[1:0]) == m.bg) ? (int'(m.lfsr[1:0]) + 1) % 4 : int'(m.lfsr[1:0]);
`else
    nxt = (m.bg + 1) % 4;
`endif
    m.lfsr = {m.lfsr[6:0], m.lfsr[7] ^ m.lfsr[5] ^ m.lfsr[4] ^ m.lfsr[3]};
    if (!m.busy) begin
      if (!au) begin
        m.dwell = 0;
        if (msel != m.bg) begin m.busy = 1; m.k = 0; m.tgt = msel; end
      end else if (press || m.dwell == hold - 1) begin
        m.busy = 1; m.k = 0; m.tgt = nxt;
      end else begin
        m.dwell++;
      end
    end else begin
      m.k++;
      if (m.k == 2*fs + 1) begin m.bg = m.tgt; m.chg = 1; end
      if (m.k == 4*fs + 1) begin m.busy = 0; m.dwell = 0; end
    end
    m.fade = m.busy ? fade_at(m.k, fs) : 3;
    return m;
  endfunction

  mdl_t ma, mb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= mdl_rst();
      mb <= mdl_rst();
    end else if (frame_tick) begin
      ma <= mdl_tick(ma, 4, 1, 8, 3, auto_en, int'(manual_sel), btn_next);
      mb <= mdl_tick(mb, 240, 2, 8, 3, auto_en, int'(manual_sel), btn_next);
    end else begin
      ma.chg <= 1'b0;
      mb.chg <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic [1:0] prev_a = 2'd0, prev_b = 2'd0;

  always @(negedge clk) begin
    chk("bg_a",    bg_a,    8'(ma.bg));
    chk("fade_a",  fade_a,  8'(ma.fade));
    chk("goose_a", goose_a, 8'(ma.goose));
    chk("chg_a",   chg_a,   8'(ma.chg));
    chk("busy_a",  busy_a,  8'(ma.busy));
    chk("bg_b",    bg_b,    8'(mb.bg));
    chk("fade_b",  fade_b,  8'(mb.fade));
    chk("goose_b", goose_b, 8'(mb.goose));
    chk("chg_b",   chg_b,   8'(mb.chg));
    chk("busy_b",  busy_b,  8'(mb.busy));
    if (chg_a) chk("new_scene_a", 8'(bg_a != prev_a), 8'd1);
    if (chg_b) chk("new_scene_b", 8'(bg_b != prev_b), 8'd1);
    prev_a <= bg_a;
    prev_b <= bg_b;
  end

  // ---------------- stimulus ----------------
  // inputs change at a negedge; the tick lands after 3 quiet edges so the
  // button synchroniser has settled; returns at the negedge after the update
  task automatic tick();
    repeat (3) @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  int fa[10] = '{3, 3, 3, 2, 1, 0, 1, 2, 3, 3};
  int fm[12] = '{2, 1, 0, 1, 2, 3, 2, 1, 0, 1, 2, 3};
  int bm[12] = '{0, 0, 0, 3, 3, 3, 3, 3, 3, 2, 2, 2};
  int nchg;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bg",   bg_a,    8'd0);
    chk("rst_fade", fade_a,  8'd3);
    chk("rst_busy", busy_a,  8'd0);
    chk("rst_gse",  goose_a, 8'd0);
    chk("rst_chg",  chg_a,   8'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // auto mode: long hold stays put, short hold walks the fade timeline
    auto_en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("hold_bg_b",   bg_b,   8'd0);
      chk("hold_fade_b", fade_b, 8'd3);
      chk("hold_busy_b", busy_b, 8'd0);
      chk("goose_b",     goose_b, (i >= 8) ? 8'd1 : 8'd0);
      chk("seq_fade_a",  fade_a, 8'(fa[i-1]));
      if (i == 7) begin
        chk("seq_bg_a",  bg_a,  8'(FIRST_BG));
        chk("seq_chg_a", chg_a, 8'd1);
      end
      if (i >= 9) chk("seq_idle_a", busy_a, 8'd0);
    end

    // manual mode: target latched at trigger despite mid-fade manual_sel change
    do_reset();
    auto_en = 1'b0;
    manual_sel = 2'd3;
    for (int j = 1; j <= 12; j++) begin
      tick();
      chk("man_fade_a", fade_a, 8'(fm[j-1]));
      chk("man_bg_a",   bg_a,   8'(bm[j-1]));
      if (j == 2) manual_sel = 2'd2;
    end
    chk("man_idle_a", busy_a, 8'd0);

    // button debounce on the long-hold instance
    do_reset();
    auto_en = 1'b1;
    manual_sel = 2'd0;
    btn_next = 1'b1;
    tick(); tick();
    chk("btn_short", busy_b, 8'd0);
    btn_next = 1'b0;
    tick();
    btn_next = 1'b1;
    tick(); tick();
    chk("btn_two", busy_b, 8'd0);
    tick();
    chk("btn_press_busy", busy_b, 8'd1);
    chk("btn_press_fade", fade_b, 8'd2);
    repeat (20) tick();
    chk("btn_hold_bg",   bg_b,   8'd1);
    chk("btn_hold_busy", busy_b, 8'd0);
    btn_next = 1'b0;
    tick();
    btn_next = 1'b1;
    repeat (3) tick();
    chk("btn_rearm", busy_b, 8'd1);
    btn_next = 1'b0;

    // reset while fading in
    do_reset();
    auto_en = 1'b1;
    repeat (16) tick();
    chk("pre_rst_fade",  fade_a,  8'd1);
    chk("pre_rst_busy",  busy_a,  8'd1);
    chk("pre_rst_goose", goose_a, 8'd2);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_bg",    bg_a,    8'd0);
    chk("mid_rst_fade",  fade_a,  8'd3);
    chk("mid_rst_busy",  busy_a,  8'd0);
    chk("mid_rst_goose", goose_a, 8'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // long auto run: every scene change must land on a new background
    nchg = 0;
    for (int t = 0; t < 800 && nchg < 50; t++) begin
      tick();
      if (chg_a) nchg++;
    end
    chk("auto_changes", 8'(nchg), 8'd50);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
